thermal_controller: RTL
=======================

THERMAL_CONTROLLER -- requirements
Module: thermal_controller

Interface
REQ-001 Parameter HEAT_T, default 8'd15, heater-on threshold (temperature below this requests heating).
REQ-002 Parameter COOL_T, default 8'd35, low-speed cooling threshold.
REQ-003 Parameter FAST_T, default 8'd50, high-speed cooling threshold.
REQ-004 Parameter ALARM_T, default 8'd60, over-temperature alarm threshold.
REQ-005 Parameter HYST, default 8'd3, hysteresis band applied on every downward/return transition.
REQ-006 Parameter DWELL, default 4, consecutive qualifying samples required before a non-alarm transition (legal range 1..15).
REQ-007 clk  input  1  single clock; all state updates on its rising edge.
REQ-008 rstN  input  1  reset; reset is asynchronous and active-low.
REQ-009 temperature  input  8  unsigned temperature from the upstream temperature calculator.
REQ-010 tempValid  input  1  one-cycle strobe; temperature is sampled only when high.
REQ-011 alarmAck  input  1  operator acknowledge, level-sampled each clock.
REQ-012 fanSpeed  output  2  registered: 0 off, 1 low, 3 high (2 unused).
REQ-013 heaterOn  output  1  registered heater enable.
REQ-014 alarm  output  1  registered over-temperature alarm.
REQ-015 ctrlState  output  3  registered current FSM state encoding.
REQ-016 maxTemp  output  8  peak-hold temperature (see Configuration).
REQ-017 alarmCount  output  8  count of ALARM entries (see Configuration).

Function
REQ-018 FSM states SHALL be IDLE, HEATING, COOL_LOW, COOL_HIGH, ALARM; evaluation occurs only on cycles with tempValid=1, except ALARM exit.
REQ-019 Any state: temperature >= ALARM_T SHALL enter ALARM on the next edge, bypassing dwell.
REQ-020 Candidate next state: IDLE -> HEATING if temp < HEAT_T, -> COOL_LOW if temp >= COOL_T; HEATING -> IDLE if temp >= HEAT_T+HYST; COOL_LOW -> COOL_HIGH if temp >= FAST_T, -> IDLE if temp < COOL_T-HYST; COOL_HIGH -> COOL_LOW if temp < FAST_T-HYST; otherwise candidate = current.
REQ-021 A dwell counter SHALL increment on each valid sample whose candidate equals the previous sample's candidate and differs from current state; it clears when candidate changes or equals current state; the transition fires on the sample that brings the count to DWELL.
REQ-022 Samples in a gap (tempValid=0) SHALL NOT clear the dwell counter.
REQ-023 Threshold arithmetic SHALL be 9-bit; THRESH-HYST never underflows given legal parameters HYST <= HEAT_T and HEAT_T+HYST < COOL_T-HYST < COOL_T < FAST_T-HYST < FAST_T < ALARM_T-HYST.
REQ-024 A register lastTemp SHALL capture temperature on every tempValid.
REQ-025 ALARM exit: cycle with alarmAck=1 and effective temp < ALARM_T-HYST -> COOL_HIGH; effective temp = incoming temperature if tempValid same cycle, else lastTemp; alarmAck in any other state or condition SHALL be ignored (not sticky).
REQ-026 Outputs SHALL be registered, valid one clock after the qualifying edge: fanSpeed IDLE/HEATING 0, COOL_LOW 1, COOL_HIGH/ALARM 3; heaterOn only in HEATING; alarm only in ALARM.
REQ-027 heaterOn and fanSpeed!=0 SHALL never be asserted simultaneously.

Reset
REQ-028 rstN low SHALL immediately force IDLE, fanSpeed=0, heaterOn=0, alarm=0, ctrlState=IDLE, dwell counter=0, lastTemp=0, maxTemp=0, alarmCount=0, regardless of in-progress dwell or ALARM.
REQ-029 tempValid and alarmAck SHALL be ignored while rstN is low; first evaluation on the first edge after release.

Configuration
REQ-030 Macro THERMAL_CTRL_STATS_EN defined: maxTemp holds the largest temperature sampled since reset; alarmCount increments on each ALARM entry, saturating at 255.
REQ-031 Macro undefined: stats registers are not built; maxTemp and alarmCount ports remain and are tied to 0.

Structure
REQ-032 Package thermal_pkg SHALL hold the state encodings (IDLE=0, HEATING=1, COOL_LOW=2, COOL_HIGH=3, ALARM=4) and fan speed constants (FAN_OFF, FAN_LOW, FAN_HIGH).
REQ-033 Dwell qualification SHALL be a sub-module sample_debouncer (inputs candidate, current state, tempValid; output fire).

Verification
REQ-034 Reset, then 4 samples temp=40 -> COOL_LOW entered on edge after 4th strobe; fanSpeed=1 one clock later; 3 samples -> still IDLE.
REQ-035 In COOL_LOW, alternate temp 51/40 for 8 samples -> dwell never completes, remains COOL_LOW.
REQ-036 From IDLE, single sample temp=61 -> ALARM next edge, alarm=1, fanSpeed=3, alarmCount=1 (macro defined).
REQ-037 In ALARM, alarmAck with lastTemp=58 -> stays ALARM; sample 56 with alarmAck same cycle -> COOL_HIGH, alarm=0.
REQ-038 In HEATING (temp=10), samples of 16 x4 -> stays HEATING; 18 x4 -> IDLE, heaterOn=0.
REQ-039 rstN pulsed low mid-dwell and in ALARM -> all outputs 0, ctrlState=IDLE asynchronously; macro undefined -> maxTemp=alarmCount=0 throughout.

Source files
------------

// File: rtl/thermal_pkg.sv
// Shared types and constants for the thermal controller: FSM state encodings,
// fan speed codes and the state-to-fan mapping.
package thermal_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    HEATING   = 3'd1,
    COOL_LOW  = 3'd2,
    COOL_HIGH = 3'd3,
    ALARM     = 3'd4
  } ctrlStateT;

  localparam logic [1:0] FAN_OFF  = 2'd0;
  localparam logic [1:0] FAN_LOW  = 2'd1;
  localparam logic [1:0] FAN_HIGH = 2'd3;

  function automatic logic [1:0] fanFor(ctrlStateT s);
    case (s)
      COOL_LOW:         fanFor = FAN_LOW;
      COOL_HIGH, ALARM: fanFor = FAN_HIGH;
      default:          fanFor = FAN_OFF;
    endcase
  endfunction

endpackage

// File: rtl/thermal_controller_if.sv
// Sample/acknowledge inputs and actuator/status outputs of the thermal controller.
interface thermal_controller_if;
  logic [7:0] temperature;
  logic       tempValid;
  logic       alarmAck;
  logic [1:0] fanSpeed;
  logic       heaterOn;
  logic       alarm;
  logic [2:0] ctrlState;
  logic [7:0] maxTemp;
  logic [7:0] alarmCount;

  modport master (
    output temperature, tempValid, alarmAck,
    input  fanSpeed, heaterOn, alarm, ctrlState, maxTemp, alarmCount
  );

  modport slave (
    input  temperature, tempValid, alarmAck,
    output fanSpeed, heaterOn, alarm, ctrlState, maxTemp, alarmCount
  );
endinterface

// File: rtl/sample_debouncer.sv
// Dwell qualification: fires when DWELL consecutive valid samples agree on the
// same candidate state that differs from the current state.
module sample_debouncer
  import thermal_pkg::*;
#(
  parameter int DWELL = 4
) (
  input  logic      clk,
  input  logic      rstN,
  input  ctrlStateT candidate,
  input  ctrlStateT current,
  input  logic      tempValid,
  output logic      fire
);

  localparam logic [3:0] DWELL_CNT = 4'(DWELL);

  logic [3:0] countReg, countNext;
  ctrlStateT  prevCandReg;

  // A fresh candidate counts as the first qualifying sample; gaps hold the count.
  always_comb begin
    countNext = countReg;
    fire      = 1'b0;
    if (tempValid) begin
      if (candidate == current)
        countNext = 4'd0;
      else if (candidate == prevCandReg)
        countNext = 4'(countReg + 4'd1);
      else
        countNext = 4'd1;
      if (candidate != current && countNext == DWELL_CNT) begin
        fire      = 1'b1;
        countNext = 4'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      countReg    <= 4'd0;
      prevCandReg <= IDLE;
    end else begin
      countReg <= countNext;
      if (tempValid)
        prevCandReg <= candidate;
    end
  end

endmodule

// File: rtl/thermal_controller.sv
// Hysteretic heater/fan FSM with dwell qualification and immediate alarm entry.
// Optional statistics (peak temperature, alarm entries) under THERMAL_CTRL_STATS_EN.
module thermal_controller
  import thermal_pkg::*;
#(
  parameter logic [7:0] HEAT_T  = 8'd15,
  parameter logic [7:0] COOL_T  = 8'd35,
  parameter logic [7:0] FAST_T  = 8'd50,
  parameter logic [7:0] ALARM_T = 8'd60,
  parameter logic [7:0] HYST    = 8'd3,
  parameter int         DWELL   = 4
) (
  input logic                  clk,
  input logic                  rstN,
  thermal_controller_if.slave  bus
);

  localparam logic [8:0] HEAT9    = {1'b0, HEAT_T};
  localparam logic [8:0] COOL9    = {1'b0, COOL_T};
  localparam logic [8:0] FAST9    = {1'b0, FAST_T};
  localparam logic [8:0] ALARM9   = {1'b0, ALARM_T};
  localparam logic [8:0] HEAT_UP  = {1'b0, HEAT_T} + {1'b0, HYST};
  localparam logic [8:0] COOL_DN  = {1'b0, COOL_T} - {1'b0, HYST};
  localparam logic [8:0] FAST_DN  = {1'b0, FAST_T} - {1'b0, HYST};
  localparam logic [8:0] ALARM_DN = {1'b0, ALARM_T} - {1'b0, HYST};

  ctrlStateT  stateReg, stateNext, candidate;
  logic       fire;
  logic [7:0] lastTempReg;
  logic [1:0] fanSpeedReg;
  logic       heaterReg, alarmReg;
  logic [8:0] temp9, eff9;

  assign temp9 = {1'b0, bus.temperature};
  assign eff9  = bus.tempValid ? temp9 : {1'b0, lastTempReg};

  always_comb begin
    candidate = stateReg;
    if (temp9 >= ALARM9) begin
      candidate = ALARM;
    end else begin
      case (stateReg)
        IDLE:      if (temp9 < HEAT9)        candidate = HEATING;
                   else if (temp9 >= COOL9)  candidate = COOL_LOW;
        HEATING:   if (temp9 >= HEAT_UP)     candidate = IDLE;
        COOL_LOW:  if (temp9 >= FAST9)       candidate = COOL_HIGH;
                   else if (temp9 < COOL_DN) candidate = IDLE;
        COOL_HIGH: if (temp9 < FAST_DN)      candidate = COOL_LOW;
        default:   candidate = stateReg;
      endcase
    end
  end

  sample_debouncer #(.DWELL(DWELL)) uDebouncer (
    .clk       (clk),
    .rstN      (rstN),
    .candidate (candidate),
    .current   (stateReg),
    .tempValid (bus.tempValid),
    .fire      (fire)
  );

  // Alarm entry bypasses dwell; alarm exit is evaluated every cycle, not only on samples.
  always_comb begin
    stateNext = stateReg;
    if (bus.tempValid && temp9 >= ALARM9)
      stateNext = ALARM;
    else if (stateReg == ALARM) begin
      if (bus.alarmAck && eff9 < ALARM_DN)
        stateNext = COOL_HIGH;
    end else if (bus.tempValid && fire)
      stateNext = candidate;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      stateReg    <= IDLE;
      lastTempReg <= 8'd0;
      fanSpeedReg <= FAN_OFF;
      heaterReg   <= 1'b0;
      alarmReg    <= 1'b0;
    end else begin
      stateReg    <= stateNext;
      fanSpeedReg <= fanFor(stateReg);
      heaterReg   <= (stateReg == HEATING);
      alarmReg    <= (stateReg == ALARM);
      if (bus.tempValid)
        lastTempReg <= bus.temperature;
    end
  end

  assign bus.fanSpeed  = fanSpeedReg;
  assign bus.heaterOn  = heaterReg;
  assign bus.alarm     = alarmReg;
  assign bus.ctrlState = stateReg;

`ifdef THERMAL_CTRL_STATS_EN
  logic [7:0] maxTempReg, alarmCountReg;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      maxTempReg    <= 8'd0;
      alarmCountReg <= 8'd0;
    end else begin
      if (bus.tempValid && bus.temperature > maxTempReg)
        maxTempReg <= bus.temperature;
      if (stateNext == ALARM && stateReg != ALARM && alarmCountReg != 8'hFF)
        alarmCountReg <= alarmCountReg + 8'd1;
    end
  end

  assign bus.maxTemp    = maxTempReg;
  assign bus.alarmCount = alarmCountReg;
`else
  assign bus.maxTemp    = 8'd0;
  assign bus.alarmCount = 8'd0;
`endif

endmodule
